// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register indices, forwarding selects and scoreboard entries.
package cpu_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int SB_DEPTH  = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_S0 = 2'd1,
        FWD_S1 = 2'd2,
        FWD_S2 = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        logic     ld;
    } sb_entry_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_match.sv
// Per-operand scoreboard lookup: picks the youngest in-flight producer of a source register.
module hazard_match
    import cpu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t sb [DEPTH],
    input  reg_idx_t  src,
    input  logic      src_used,
    output fwd_sel_e  sel,
    output logic      load_use
);

    logic hit;

    // NOTE: every output and the loop flag get a default first, so no path leaves them unassigned (no latch).
    always_comb begin
        sel      = FWD_RF;
        load_use = 1'b0;
        hit      = 1'b0;
        // Scanning from slot0 upward and stopping at the first hit makes the youngest producer win.
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && src_used && (src != REG_ZERO) && sb[i].v && (sb[i].rd == src)) begin
                hit = 1'b1;
                if ((i == 0) && sb[i].ld) begin
                    load_use = 1'b1;
                end else begin
                    sel = fwd_sel_e'(2'(i + 1));
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Issue/hazard controller between decode and execute: scoreboard, load-use stall and operand forwarding.
module hazard_scheduler
    import cpu_pkg::*;
#(
    parameter int NREG  = NUM_REGS,
    parameter int REG_W = $clog2(NREG),
    parameter int DEPTH = SB_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_50,
    input  logic             RSTN_N,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             ext_hold,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t sb [DEPTH];
    fwd_sel_e  sel1, sel2;
    logic      load_use1, load_use2;

    hazard_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .sb       (sb),
        .src      (id_rs1),
        .src_used (id_use_rs1),
        .sel      (sel1),
        .load_use (load_use1)
    );

    hazard_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .sb       (sb),
        .src      (id_rs2),
        .src_used (id_use_rs2),
        .sel      (sel2),
        .load_use (load_use2)
    );

    // A flush kills the decode instruction, so it can neither stall nor be counted.
    assign stall    = id_valid & ~flush & (load_use1 | load_use2);
    assign issue    = id_valid & ~stall & ~flush & ~ext_hold;
    assign fwd_sel1 = sel1;
    assign fwd_sel2 = sel2;

    // NOTE: the scoreboard must be cleared on reset; a stale valid entry would forward garbage after release.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb[i] <= '0;
            end
            stall_cnt <= '0;
        end else if (!ext_hold) begin
            if (issue) begin
                sb[0] <= '{v: id_we && (id_rd != REG_ZERO), rd: id_rd, ld: id_is_load};
            end else begin
                sb[0] <= '0;
            end
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb[i] <= sb[i-1];
            end
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus randomized traffic against an age-based model.
module tb_hazard_scheduler;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLOCK_50 = 1'b0;
    logic             RSTN_N   = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic             id_we = 1'b0, id_is_load = 1'b0;
    logic             flush = 1'b0, ext_hold = 1'b0;
    logic             stall, issue;
    logic [1:0]       fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    hazard_scheduler #(.CNT_W(CNT_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .RSTN_N     (RSTN_N),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .ext_hold   (ext_hold),
        .stall      (stall),
        .issue      (issue),
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .stall_cnt  (stall_cnt)
    );

    // Model: list of issued register writers stamped with the pipeline-advance count at issue.
    // Age = advances since issue; age 0 is EX/MEM, age 2 is the write-back cycle, age 3 has retired.
    typedef struct {
        int unsigned t;
        int          rd;
        bit          ld;
        int          val;
    } rec_t;

    rec_t        flight[$];
    int unsigned adv   = 0;
    int          m_cnt = 0;
    int          rf [32];

    function automatic void m_match(input int s, input bit used, output logic [1:0] sel, output bit lu);
        int best = 99;
        int bi   = -1;
        sel = 2'd0;
        lu  = 1'b0;
        if (used && s != 0) begin
            foreach (flight[k]) begin
                if (flight[k].rd == s && int'(adv - flight[k].t) < best) begin
                    best = int'(adv - flight[k].t);
                    bi   = k;
                end
            end
        end
        if (bi >= 0 && best < 3) begin
            if (best == 0 && flight[bi].ld) lu = 1'b1;
            else sel = 2'(best + 1);
        end
    endfunction

    function automatic void m_eval(output bit st, output bit iss, output logic [1:0] s1, output logic [1:0] s2);
        bit lu1, lu2;
        m_match(int'(id_rs1), id_use_rs1, s1, lu1);
        m_match(int'(id_rs2), id_use_rs2, s2, lu2);
        st  = id_valid && !flush && (lu1 || lu2);
        iss = id_valid && !st && !flush && !ext_hold;
    endfunction

    // Operand value seen by execute for a given select, used to rebuild architectural results.
    function automatic int opnd(input logic [1:0] sel, input int s);
        if (s == 0) return 0;
        if (sel == 2'd0) return rf[s];
        foreach (flight[k]) begin
            if (flight[k].rd == s && int'(adv - flight[k].t) == int'(sel) - 1) return flight[k].val;
        end
        return -1000;
    endfunction

    task automatic tick(input int val = 0);
        bit st, iss, we, ld, hold;
        logic [1:0] a, b;
        int rd;
        m_eval(st, iss, a, b);
        we = id_we; ld = id_is_load; hold = ext_hold; rd = int'(id_rd);
        @(posedge CLOCK_50);
        if (RSTN_N && !hold) begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            adv++;
            if (iss && we && rd != 0) flight.push_back('{t: adv, rd: rd, ld: ld, val: val});
            while (flight.size() > 0 && adv - flight[0].t >= 3) begin
                rf[flight[0].rd] = flight[0].val;
                void'(flight.pop_front());
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input int rd, input bit we, input bit ld,
                          input int rs1, input bit u1, input int rs2, input bit u2);
        id_valid = v; id_rd = 5'(rd); id_we = we; id_is_load = ld;
        id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        flush = 1'b0; ext_hold = 1'b0;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        RSTN_N = 1'b0;
        flight.delete();
        m_cnt = 0;
        @(negedge CLOCK_50);
        RSTN_N = 1'b1;
        tick();
    endtask

    task automatic cmp_model(input string name);
        bit st, iss;
        logic [1:0] a, b;
        m_eval(st, iss, a, b);
        checks++;
        if ({stall, issue, fwd_sel1, fwd_sel2, stall_cnt} !== {st, iss, a, b, CNT_W'(m_cnt)}) begin
            errors++;
            $display("FAIL %s: got stall=%b issue=%b sel1=%0d sel2=%0d cnt=%0d, want stall=%b issue=%b sel1=%0d sel2=%0d cnt=%0d",
                     name, stall, issue, fwd_sel1, fwd_sel2, stall_cnt, st, iss, a, b, m_cnt);
        end
    endtask

    task automatic test_reset();
        set_id(1, 3, 1, 0, 1, 1, 2, 1);
        RSTN_N = 1'b0;
        #2;
        checks++;
        if ({stall, issue, fwd_sel1, fwd_sel2, stall_cnt} !== {1'b0, 1'b1, 2'd0, 2'd0, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_state: got stall=%b issue=%b sel1=%0d sel2=%0d cnt=%0d, want 0 1 0 0 0",
                     stall, issue, fwd_sel1, fwd_sel2, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_alu_chain();
        int v;
        do_reset();
        rf[1] = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 1, 1, 0, 1, 1, 1, 1);
            @(negedge CLOCK_50);
            cmp_model("alu_chain_model");
            checks++;
            if ({fwd_sel1, fwd_sel2, stall} !== {(k == 0) ? 4'b0000 : 4'b0101, 1'b0}) begin
                errors++;
                $display("FAIL alu_chain_sel%0d: got sel1=%0d sel2=%0d stall=%b, want sel=%0d stall=0",
                         k, fwd_sel1, fwd_sel2, stall, (k == 0) ? 0 : 1);
            end
            v = opnd(fwd_sel1, 1) + opnd(fwd_sel2, 1);
            tick(v);
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge CLOCK_50);
        checks++;
        if (rf[1] !== 8 || stall_cnt !== CNT_W'(0)) begin
            errors++;
            $display("FAIL alu_chain_result: got r1=%0d cnt=%0d, want r1=8 cnt=0", rf[1], stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 2, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 1, 0, 2, 1, 2, 1);
        @(negedge CLOCK_50);
        cmp_model("load_use_stall_model");
        checks++;
        if ({stall, issue} !== 2'b10) begin
            errors++;
            $display("FAIL load_use_stall: got stall=%b issue=%b, want 1 0", stall, issue);
        end
        tick();
        @(negedge CLOCK_50);
        cmp_model("load_use_resolve_model");
        checks++;
        if ({stall, issue, fwd_sel1, fwd_sel2} !== {1'b0, 1'b1, 2'd2, 2'd2}) begin
            errors++;
            $display("FAIL load_use_resolve: got stall=%b issue=%b sel1=%0d sel2=%0d, want 0 1 2 2",
                     stall, issue, fwd_sel1, fwd_sel2);
        end
        tick();
        @(negedge CLOCK_50);
        checks++;
        if (stall_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_use_count: got %0d, want 1", stall_cnt);
        end
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1, 0, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 1, 0, 1);
        @(negedge CLOCK_50);
        checks++;
        if ({stall, fwd_sel1, fwd_sel2} !== 5'b0) begin
            errors++;
            $display("FAIL r0_read: got stall=%b sel1=%0d sel2=%0d, want 0 0 0", stall, fwd_sel1, fwd_sel2);
        end
        tick();
    endtask

    task automatic test_distance();
        do_reset();
        set_id(1, 4, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 6, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 7, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 4, 1, 9, 1);
        @(negedge CLOCK_50);
        cmp_model("distance3_model");
        checks++;
        if (fwd_sel1 !== 2'd3) begin
            errors++;
            $display("FAIL distance3_sel: got %0d, want 3", fwd_sel1);
        end
        tick();
        @(negedge CLOCK_50);
        checks++;
        if (fwd_sel1 !== 2'd0) begin
            errors++;
            $display("FAIL distance4_sel: got %0d, want 0", fwd_sel1);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 2, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 1, 0, 2, 1, 0, 0);
        flush = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({stall, issue} !== 2'b00) begin
            errors++;
            $display("FAIL flush_hazard: got stall=%b issue=%b, want 0 0", stall, issue);
        end
        tick();
        flush = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if ({stall, issue, fwd_sel1, stall_cnt} !== {1'b0, 1'b1, 2'd2, CNT_W'(0)}) begin
            errors++;
            $display("FAIL flush_after: got stall=%b issue=%b sel1=%0d cnt=%0d, want 0 1 2 0",
                     stall, issue, fwd_sel1, stall_cnt);
        end
        tick();
    endtask

    task automatic test_hold_then_reset();
        do_reset();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 8, 1, 0, 5, 1, 5, 1);
        ext_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLOCK_50);
            checks++;
            if ({stall, issue, fwd_sel1, fwd_sel2} !== {1'b0, 1'b0, 2'd1, 2'd1}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got stall=%b issue=%b sel1=%0d sel2=%0d, want 0 0 1 1",
                         k, stall, issue, fwd_sel1, fwd_sel2);
            end
            tick();
        end
        ext_hold = 1'b0;
        RSTN_N   = 1'b0;
        #2;
        checks++;
        if ({stall, issue, fwd_sel1, fwd_sel2, stall_cnt} !== {1'b0, 1'b1, 2'd0, 2'd0, CNT_W'(0)}) begin
            errors++;
            $display("FAIL hold_reset: got stall=%b issue=%b sel1=%0d sel2=%0d cnt=%0d, want 0 1 0 0 0",
                     stall, issue, fwd_sel1, fwd_sel2, stall_cnt);
        end
        do_reset();
        set_id(1, 8, 1, 0, 5, 1, 5, 1);
        @(negedge CLOCK_50);
        cmp_model("post_reset_no_stale");
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            set_id(1, 2, 1, 1, 0, 0, 0, 0);
            tick();
            set_id(1, 3, 1, 0, 2, 1, 0, 0);
            tick();
            tick();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        checks++;
        if (stall_cnt !== CNT_W'(CNT_MAX) || m_cnt != CNT_MAX) begin
            errors++;
            $display("FAIL stall_cnt_saturate: got %0d (model %0d), want %0d", stall_cnt, m_cnt, CNT_MAX);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) id_rs2 = id_rs1;
            flush    = ($urandom_range(0, 9) == 0);
            ext_hold = ($urandom_range(0, 9) == 0);
            @(negedge CLOCK_50);
            cmp_model("random");
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (rf[i]) rf[i] = 0;
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_r0();
        test_distance();
        test_flush();
        test_hold_then_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
